multicycle_controller: RTL and testbench



---
 rtl/kgp_risc_pkg.sv | 77 +++++++
 rtl/control_decoder.sv | 58 +++++
 rtl/multicycle_controller.sv | 153 +++++++++++++++
 tb/tb_multicycle_controller.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg
//   Shared types and constants for the KGP_RISC multi-cycle control unit:
//   FSM state enum, instruction-class enum, opcode constants and class
//   prefixes, datapath mux encodings and the registered control bundle.
package kgp_risc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  // The class decides the state path after DECODE and which strobes fire.
  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,  // R-type and ALU-immediate
    CLS_LW      = 3'd1,
    CLS_SW      = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JAL     = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_t;

  // Full opcodes
  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b010000;
  localparam logic [5:0] OP_SW     = 6'b010001;
  localparam logic [5:0] OP_JAL    = 6'b100000;
  localparam logic [5:0] OP_HALT   = 6'b111111;

  // Class prefixes (opcode[5:3]) and the R-type shift group (funccode[5:3])
  localparam logic [2:0] PFX_ALU_IMM  = 3'b001;
  localparam logic [2:0] PFX_BRANCH   = 3'b011;
  localparam logic [2:0] FN_PFX_SHIFT = 3'b001;

  // ALU B operand select
  localparam logic [1:0] SRC_RT     = 2'b00;
  localparam logic [1:0] SRC_OFFSET = 2'b01;
  localparam logic [1:0] SRC_SHAMT  = 2'b10;

  // Write-back select
  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_NEXT_PC = 2'b10;

  // Destination register select
  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] BR_NONE   = 3'b000;
  localparam logic [2:0] BR_ALWAYS = 3'b111;

  typedef struct packed {
    instr_class_t cls;
    logic [2:0]   alu_op;
    logic [1:0]   alu_src;
    logic [1:0]   reg_dest;
    logic [1:0]   mem_to_reg;
    logic [2:0]   branch;
  } ctrl_bundle_t;

  // Bundle used at reset and as the decoder's starting point.
  localparam ctrl_bundle_t CTRL_NOP = '{
    cls:        CLS_ALU,
    alu_op:     ALU_ADD,
    alu_src:    SRC_RT,
    reg_dest:   DST_RT,
    mem_to_reg: WB_ALU,
    branch:     BR_NONE
  };

endpackage

// File: rtl/control_decoder.sv
// control_decoder
//   Purely combinational map from the decoded instruction fields to the
//   control bundle. The FSM samples the result while in DECODE.
//   Ports:
//     opcode   in  6  instruction opcode
//     funccode in  6  R-type function code
//     bundle   out    control bundle (class + datapath selects)
//     illegal  out 1  opcode matches no defined class
module control_decoder
  import kgp_risc_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funccode,
  output ctrl_bundle_t bundle,
  output logic         illegal
);

  always_comb begin
    bundle  = CTRL_NOP;
    illegal = 1'b0;
    if (opcode == OP_R_TYPE) begin
      bundle.cls        = CLS_ALU;
      bundle.alu_op     = funccode[2:0];
      bundle.alu_src    = (funccode[5:3] == FN_PFX_SHIFT) ? SRC_SHAMT : SRC_RT;
      bundle.reg_dest   = DST_RD;
      bundle.mem_to_reg = WB_ALU;
    end else if (opcode[5:3] == PFX_ALU_IMM) begin
      bundle.cls      = CLS_ALU;
      bundle.alu_op   = opcode[2:0];
      bundle.alu_src  = SRC_OFFSET;
      bundle.reg_dest = DST_RT;
    end else if (opcode == OP_LW) begin
      bundle.cls        = CLS_LW;
      bundle.alu_op     = ALU_ADD;
      bundle.alu_src    = SRC_OFFSET;
      bundle.mem_to_reg = WB_MEM;
      bundle.reg_dest   = DST_RT;
    end else if (opcode == OP_SW) begin
      bundle.cls     = CLS_SW;
      bundle.alu_op  = ALU_ADD;
      bundle.alu_src = SRC_OFFSET;
    end else if (opcode[5:3] == PFX_BRANCH && opcode[2:0] != 3'b000) begin
      bundle.cls    = CLS_BRANCH;
      bundle.branch = opcode[2:0];
    end else if (opcode == OP_JAL) begin
      bundle.cls        = CLS_JAL;
      bundle.mem_to_reg = WB_NEXT_PC;
      bundle.reg_dest   = DST_R31;
      bundle.branch     = BR_ALWAYS;
    end else if (opcode == OP_HALT) begin
      bundle.cls = CLS_HALT;
    end else begin
      bundle.cls = CLS_ILLEGAL;
      illegal    = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle control FSM for the KGP_RISC datapath. Sequences
//   FETCH/DECODE/EXECUTE/MEM/WRITEBACK, holds the decoded control bundle
//   for the life of the instruction and counts retired instructions.
//   Ports:
//     clk, rst            clock, async active-high reset
//     opcode, funccode    decoded instruction fields
//     imem_ack            instruction memory data valid (FETCH only)
//     dmem_ready          data memory access done (MEM only)
//     imem_req, ir_load   fetch handshake / IR load strobe
//     reg_dest, ALUop, ALUsource, mem_to_reg   held datapath selects
//     reg_write, mem_write, pc_write, branch   per-cycle strobes
//     illegal, halted     undefined-opcode pulse / core stopped
//     retired             completed-instruction count (wraps)
module multicycle_controller
  import kgp_risc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funccode,
  input  logic        imem_ack,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic [1:0]  reg_dest,
  output logic        reg_write,
  output logic [2:0]  ALUop,
  output logic [1:0]  ALUsource,
  output logic        mem_write,
  output logic [1:0]  mem_to_reg,
  output logic [2:0]  branch,
  output logic        pc_write,
  output logic        illegal,
  output logic        halted,
  output logic [31:0] retired
);

  state_t       state_q, state_d;
  ctrl_bundle_t dec_bundle;
  logic         dec_illegal;
  ctrl_bundle_t ctl_q;
  logic [31:0]  retired_q;

  control_decoder u_decoder (
    .opcode   (opcode),
    .funccode (funccode),
    .bundle   (dec_bundle),
    .illegal  (dec_illegal)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic. DECODE routes on the live decoder output; later
  // states route on the bundle captured when DECODE was left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (imem_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        case (dec_bundle.cls)
          CLS_ALU, CLS_LW, CLS_SW, CLS_BRANCH: state_d = ST_EXECUTE;
          CLS_JAL:                             state_d = ST_WRITEBACK;
          CLS_HALT:                            state_d = ST_HALT;
          default:                             state_d = ST_FETCH;
        endcase
      end
      ST_EXECUTE: begin
        case (ctl_q.cls)
          CLS_LW, CLS_SW: state_d = ST_MEM;
          CLS_BRANCH:     state_d = ST_FETCH;
          default:        state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEM: if (dmem_ready) state_d = (ctl_q.cls == CLS_SW) ? ST_FETCH : ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Control bundle is captured on the DECODE exit edge only, so the
  // datapath selects stay put from EXECUTE until the next instruction's
  // DECODE completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ctl_q <= CTRL_NOP;
    else if (state_q == ST_DECODE)  ctl_q <= dec_bundle;
  end

  // Output logic. Everything is forced low while rst is high so an
  // instruction interrupted by reset cannot emit a stray strobe, and so
  // imem_req only rises once reset has been released.
  always_comb begin
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    pc_write  = 1'b0;
    branch    = BR_NONE;
    illegal   = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ack;
        end
        ST_DECODE: begin
          // ctl_q still holds the previous instruction here, so branch
          // stays at BR_NONE for the illegal-opcode pc_write.
          illegal  = dec_illegal;
          pc_write = dec_illegal;
        end
        ST_EXECUTE: begin
          if (ctl_q.cls == CLS_BRANCH) begin
            pc_write = 1'b1;
            branch   = ctl_q.branch;
          end
        end
        ST_MEM: begin
          mem_write = (ctl_q.cls == CLS_SW);
          pc_write  = (ctl_q.cls == CLS_SW) && dmem_ready;
        end
        ST_WRITEBACK: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          // Non-zero only for jal; ALU and lw bundles carry BR_NONE.
          branch    = ctl_q.branch;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign ALUop      = ctl_q.alu_op;
  assign ALUsource  = ctl_q.alu_src;
  assign reg_dest   = ctl_q.reg_dest;
  assign mem_to_reg = ctl_q.mem_to_reg;

  // Retired counter: one tick per completed instruction, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           retired_q <= '0;
    else if (pc_write) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funccode = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, ir_load, reg_write, mem_write, pc_write, illegal, halted;
  logic [1:0]  reg_dest, ALUsource, mem_to_reg;
  logic [2:0]  ALUop, branch;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funccode   (funccode),
    .imem_ack   (imem_ack),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .reg_dest   (reg_dest),
    .reg_write  (reg_write),
    .ALUop      (ALUop),
    .ALUsource  (ALUsource),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .branch     (branch),
    .pc_write   (pc_write),
    .illegal    (illegal),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // All outputs except retired, packed for all-zero checks.
  logic [18:0] all_out;
  assign all_out = {imem_req, ir_load, reg_write, mem_write, pc_write, illegal, halted,
                    ALUop, ALUsource, reg_dest, mem_to_reg, branch};

  // Cycles start at a falling edge: drive inputs, let them settle, sample,
  // then wait for the next falling edge.
  task automatic cyc_begin(input logic ack, input logic rdy);
    imem_ack   = ack;
    dmem_ready = rdy;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (all_out !== 19'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    @(negedge clk);
    rst = 1'b0;
    cyc_begin(1'b0, 1'b0);
    checks++;
    if ({imem_req, ir_load} !== 2'b10) begin errors++; $display("FAIL reset_first_fetch: got %b expected 10", {imem_req, ir_load}); end
    @(negedge clk);
    cyc_begin(1'b0, 1'b0);
    checks++;
    if ({imem_req, ir_load} !== 2'b10) begin errors++; $display("FAIL fetch_wait: got %b expected 10", {imem_req, ir_load}); end
    @(negedge clk);
  endtask

  task automatic test_rtype_add;
    logic [4:0] rw_h, pw_h;
    rw_h = '0; pw_h = '0;
    do_reset;
    opcode = 6'b000000; funccode = 6'b000001;
    for (int c = 1; c <= 4; c++) begin
      cyc_begin(c == 1, 1'b0);
      rw_h[c] = reg_write; pw_h[c] = pc_write;
      if (c == 1) begin
        checks++;
        if (ir_load !== 1'b1) begin errors++; $display("FAIL rtype_ir_load: got %b expected 1", ir_load); end
      end
      if (c == 3) begin
        checks++;
        if ({ALUop, ALUsource, reg_dest} !== {3'b001, 2'b00, 2'b01}) begin
          errors++; $display("FAIL rtype_bundle: got %b expected 0010001", {ALUop, ALUsource, reg_dest});
        end
      end
      @(negedge clk);
    end
    checks++;
    if (rw_h !== 5'b10000) begin errors++; $display("FAIL rtype_reg_write_cycle: got %b expected 10000", rw_h); end
    checks++;
    if (pw_h !== 5'b10000) begin errors++; $display("FAIL rtype_pc_write_cycle: got %b expected 10000", pw_h); end
    cyc_begin(1'b0, 1'b0);
    checks++;
    if (retired !== 32'd1) begin errors++; $display("FAIL rtype_retired: got %0d expected 1", retired); end
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rtype_back_to_fetch: got %b expected 1", imem_req); end
    @(negedge clk);
  endtask

  task automatic test_alu_variants;
    do_reset;
    // R-type shift group
    opcode = 6'b000000; funccode = 6'b001011;
    for (int c = 1; c <= 4; c++) begin
      cyc_begin(c == 1, 1'b0);
      if (c == 3) begin
        checks++;
        if ({ALUop, ALUsource, reg_dest} !== {3'b011, 2'b10, 2'b01}) begin
          errors++; $display("FAIL shift_bundle: got %b expected 0111001", {ALUop, ALUsource, reg_dest});
        end
      end
      @(negedge clk);
    end
    // ALU-immediate, back to back
    opcode = 6'b001101; funccode = 6'b000000;
    for (int c = 1; c <= 4; c++) begin
      cyc_begin(c == 1, 1'b0);
      if (c == 2) begin
        checks++;
        if (ALUop !== 3'b011) begin errors++; $display("FAIL aluop_held_in_decode: got %b expected 011", ALUop); end
      end
      if (c == 3) begin
        checks++;
        if ({ALUop, ALUsource, reg_dest} !== {3'b101, 2'b01, 2'b00}) begin
          errors++; $display("FAIL imm_bundle: got %b expected 1010100", {ALUop, ALUsource, reg_dest});
        end
      end
      if (c == 4) begin
        checks++;
        if ({reg_write, pc_write, mem_to_reg, branch} !== {1'b1, 1'b1, 2'b00, 3'b000}) begin
          errors++; $display("FAIL imm_writeback: got %b expected 1100000", {reg_write, pc_write, mem_to_reg, branch});
        end
      end
      @(negedge clk);
    end
    cyc_begin(1'b0, 1'b0);
    checks++;
    if (retired !== 32'd2) begin errors++; $display("FAIL alu_variants_retired: got %0d expected 2", retired); end
    @(negedge clk);
  endtask

  task automatic test_lw_wait;
    logic [10:0] rw_h, pw_h, il_h;
    rw_h = '0; pw_h = '0; il_h = '0;
    do_reset;
    opcode = 6'b010000; funccode = 6'b000000;
    // ack in cycle 3 (and a held-over ack in DECODE), ready in cycle 9
    // plus a spurious ready in EXECUTE.
    for (int c = 1; c <= 10; c++) begin
      cyc_begin(c == 3 || c == 4, c == 5 || c == 9);
      rw_h[c] = reg_write; pw_h[c] = pc_write; il_h[c] = ir_load;
      if (c == 10) begin
        checks++;
        if (mem_to_reg !== 2'b01) begin errors++; $display("FAIL lw_mem_to_reg: got %b expected 01", mem_to_reg); end
      end
      @(negedge clk);
    end
    checks++;
    if (rw_h !== 11'b10000000000) begin errors++; $display("FAIL lw_reg_write_cycle: got %b expected 10000000000", rw_h); end
    checks++;
    if (pw_h !== 11'b10000000000) begin errors++; $display("FAIL lw_pc_write_cycle: got %b expected 10000000000", pw_h); end
    checks++;
    if (il_h !== 11'b00000001000) begin errors++; $display("FAIL lw_ir_load_single: got %b expected 00000001000", il_h); end
    cyc_begin(1'b0, 1'b0);
    checks++;
    if ({imem_req, retired} !== {1'b1, 32'd1}) begin errors++; $display("FAIL lw_done: got req=%b ret=%0d expected req=1 ret=1", imem_req, retired); end
    @(negedge clk);
  endtask

  task automatic test_sw_branch;
    logic [5:0] mw_h, rw_h, pw_h;
    logic [2:0] br_early;
    mw_h = '0; rw_h = '0; pw_h = '0; br_early = '0;
    do_reset;
    opcode = 6'b010001;
    for (int c = 1; c <= 5; c++) begin
      cyc_begin(c == 1, c == 5);
      mw_h[c] = mem_write; rw_h[c] = reg_write; pw_h[c] = pc_write;
      @(negedge clk);
    end
    checks++;
    if (mw_h !== 6'b110000) begin errors++; $display("FAIL sw_mem_write: got %b expected 110000", mw_h); end
    checks++;
    if (rw_h !== 6'b000000) begin errors++; $display("FAIL sw_no_reg_write: got %b expected 000000", rw_h); end
    checks++;
    if (pw_h !== 6'b100000) begin errors++; $display("FAIL sw_pc_write: got %b expected 100000", pw_h); end
    opcode = 6'b011010;
    for (int c = 1; c <= 3; c++) begin
      cyc_begin(c == 1, 1'b0);
      if (c < 3) br_early = br_early | branch;
      if (c == 3) begin
        checks++;
        if ({branch, pc_write, reg_write, mem_write} !== {3'b010, 1'b1, 1'b0, 1'b0}) begin
          errors++; $display("FAIL branch_cycle3: got %b expected 010100", {branch, pc_write, reg_write, mem_write});
        end
      end
      @(negedge clk);
    end
    checks++;
    if (br_early !== 3'b000) begin errors++; $display("FAIL branch_early_zero: got %b expected 000", br_early); end
    cyc_begin(1'b0, 1'b0);
    checks++;
    if ({branch, retired} !== {3'b000, 32'd2}) begin errors++; $display("FAIL branch_after: got br=%b ret=%0d expected br=000 ret=2", branch, retired); end
    @(negedge clk);
  endtask

  task automatic test_jal;
    do_reset;
    opcode = 6'b100000;
    cyc_begin(1'b1, 1'b0);
    @(negedge clk);
    cyc_begin(1'b0, 1'b0);
    checks++;
    if ({branch, pc_write} !== 4'b0000) begin errors++; $display("FAIL jal_decode_quiet: got %b expected 0000", {branch, pc_write}); end
    @(negedge clk);
    cyc_begin(1'b0, 1'b0);
    checks++;
    if ({mem_to_reg, reg_dest, branch, reg_write, pc_write} !== {2'b10, 2'b10, 3'b111, 1'b1, 1'b1}) begin
      errors++; $display("FAIL jal_writeback: got %b expected 101011111", {mem_to_reg, reg_dest, branch, reg_write, pc_write});
    end
    @(negedge clk);
    cyc_begin(1'b0, 1'b0);
    checks++;
    if ({imem_req, branch} !== 4'b1000) begin errors++; $display("FAIL jal_after: got %b expected 1000", {imem_req, branch}); end
    @(negedge clk);
  endtask

  task automatic test_illegal_halt;
    int req_cnt, halt_cnt, pw_cnt;
    req_cnt = 0; halt_cnt = 0; pw_cnt = 0;
    do_reset;
    opcode = 6'b110101;
    cyc_begin(1'b1, 1'b0);
    @(negedge clk);
    cyc_begin(1'b0, 1'b0);
    checks++;
    if ({illegal, pc_write, reg_write, branch} !== {1'b1, 1'b1, 1'b0, 3'b000}) begin
      errors++; $display("FAIL illegal_decode: got %b expected 110000", {illegal, pc_write, reg_write, branch});
    end
    @(negedge clk);
    opcode = 6'b111111;
    cyc_begin(1'b1, 1'b0);
    checks++;
    if ({imem_req, illegal, retired} !== {1'b1, 1'b0, 32'd1}) begin
      errors++; $display("FAIL illegal_return: got req=%b ill=%b ret=%0d expected req=1 ill=0 ret=1", imem_req, illegal, retired);
    end
    @(negedge clk);
    cyc_begin(1'b0, 1'b0);
    checks++;
    if ({halted, pc_write} !== 2'b00) begin errors++; $display("FAIL halt_decode: got %b expected 00", {halted, pc_write}); end
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      cyc_begin(1'b1, 1'b1);
      req_cnt  += int'(imem_req);
      halt_cnt += int'(halted);
      pw_cnt   += int'(pc_write | reg_write | mem_write | ir_load);
      @(negedge clk);
    end
    checks++;
    if (req_cnt !== 0) begin errors++; $display("FAIL halt_no_req: got %0d expected 0", req_cnt); end
    checks++;
    if (halt_cnt !== 20) begin errors++; $display("FAIL halt_held: got %0d expected 20", halt_cnt); end
    checks++;
    if ({pw_cnt, retired} !== {32'd0, 32'd1}) begin errors++; $display("FAIL halt_quiet: got strobes=%0d ret=%0d expected 0 and 1", pw_cnt, retired); end
  endtask

  task automatic test_reset_mid_mem;
    do_reset;
    opcode = 6'b010000;
    for (int c = 1; c <= 5; c++) begin
      cyc_begin(c == 1, 1'b0);
      @(negedge clk);
    end
    // Still waiting in MEM; reset hits with a ready that must be ignored.
    rst = 1'b1;
    dmem_ready = 1'b1;
    #1;
    checks++;
    if ({all_out, retired} !== 51'd0) begin errors++; $display("FAIL midmem_reset_outputs: got %h/%0d expected 0", all_out, retired); end
    @(negedge clk);
    checks++;
    if ({reg_write, retired} !== 33'd0) begin errors++; $display("FAIL midmem_no_writeback: got rw=%b ret=%0d expected 0", reg_write, retired); end
    rst = 1'b0;
    cyc_begin(1'b1, 1'b0);
    checks++;
    if ({imem_req, ir_load, reg_write, retired} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
      errors++; $display("FAIL midmem_resume: got req=%b ld=%b rw=%b ret=%0d expected 1 1 0 0", imem_req, ir_load, reg_write, retired);
    end
    @(negedge clk);
    for (int c = 2; c <= 5; c++) begin
      cyc_begin(1'b0, c == 4);
      if (c == 5) begin
        checks++;
        if ({reg_write, mem_to_reg} !== 3'b101) begin errors++; $display("FAIL midmem_rerun_wb: got %b expected 101", {reg_write, mem_to_reg}); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_rtype_add;
    test_alu_variants;
    test_lw_wait;
    test_sw_branch;
    test_jal;
    test_illegal_halt;
    test_reset_mid_mem;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
